// File: rtl/aont_pkg.sv
// Shared constants, types and arithmetic helper for the latin-square AONT decoder.
//   MSGLEN/NOOFBLOCKS/LSLEN/LSLENLOG : fixed geometry (512-bit message, 8 blocks of 16 nibbles)
//   nibble_t / block_t / pkt_t / sq_t : packed views of symbols, blocks, packets and the square
//   state_t                           : decoder FSM states
//   mulmod17_t4                       : (a*b) mod 17, truncated to a nibble (16 -> 0)
package aont_pkg;

  localparam int MSGLEN     = 512;
  localparam int NOOFBLOCKS = 8;
  localparam int LSLEN      = 16;
  localparam int LSLENLOG   = 4;

  typedef logic [LSLENLOG-1:0]          nibble_t;
  typedef nibble_t [LSLEN-1:0]          block_t;
  typedef block_t  [NOOFBLOCKS:0]       pkt_t;
  typedef nibble_t [LSLEN*LSLEN-1:0]    sq_t;

  typedef enum logic [1:0] {
    IDLE,
    LEADER,
    DECODE,
    DONE
  } state_t;

  // The residue mod 17 can be 16; keeping only the low nibble maps it to 0.
  function automatic nibble_t mulmod17_t4(input nibble_t a, input nibble_t b);
    logic [7:0] prod;
    prod = {4'b0000, a} * {4'b0000, b};
    return 4'(prod % 8'd17);
  endfunction

endpackage

// File: rtl/latin_sq_ldiv.sv
// Latin-square left division: finds the lowest column c with L(row, c) == target.
//   sq     : latin square, entry L(r,c) at index 16r+c
//   row    : row to search
//   target : symbol being looked for
//   col    : lowest matching column (0 when nothing matches)
//   found  : a match exists in the row
module latin_sq_ldiv
  import aont_pkg::*;
(
  input  sq_t     sq,
  input  nibble_t row,
  input  nibble_t target,
  output nibble_t col,
  output logic    found
);

  // Scan from the top down so the last hit written is the lowest column.
  always_comb begin
    col   = '0;
    found = 1'b0;
    for (int c = LSLEN - 1; c >= 0; c--) begin
      if (sq[{row, 4'(c)}] == target) begin
        col   = 4'(c);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/aont_inv.sv
// Inverse latin-square all-or-nothing transform (receive-side decoder).
// Recovers one message nibble per cycle from an encoded packet of 8 data
// blocks plus a check block.
//   clk, rstn          : clock, asynchronous active-high reset (asserted = 1)
//   in_valid/in_ready  : packet + key handshake; blk_in and k are captured on accept
//   blk_in[575:0]      : encoded packet, block i at [64i+63:64i], block 8 is the check block
//   k[63:0]            : key, nibble j at [4j+3:4j]
//   sq_in[1023:0]      : latin square, read live; must stay stable until the output handshake
//   out_valid/out_ready: recovered-message handshake
//   msg_out[511:0]     : recovered message
//   sq_err             : a column search failed in this packet
//   mac_ok             : check block verified (only with AONT_CHECK_EN, otherwise 0)
// Build option: define AONT_CHECK_EN to add the check-block accumulators and mac_ok.
module aont_inv
  import aont_pkg::*;
(
  input  logic          clk,
  input  logic          rstn,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [575:0]  blk_in,
  input  logic [63:0]   k,
  input  logic [1023:0] sq_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [511:0]  msg_out,
  output logic          sq_err,
  output logic          mac_ok
);

  sq_t                     sq;
  state_t                  state;
  block_t [NOOFBLOCKS-1:0] dat_q;
  block_t                  key_q;
  block_t [NOOFBLOCKS-1:0] msg_q;
  nibble_t                 leader;
  nibble_t                 e_q;
  logic [3:0]              step;
  logic [2:0]              blk;
  logic [3:0]              col;
  logic                    err_q;

  nibble_t                 e_cur;
  nibble_t                 b_cur;
  nibble_t                 m_cur;
  logic                    found;
  logic                    accept;
  logic                    last_cell;

  assign sq        = sq_in;
  assign accept    = (state == IDLE) && in_valid && in_ready;
  assign last_cell = (blk == 3'd7) && (col == 4'd15);

  // Each block restarts its symbol chain from L(leader, 0); within a block
  // the chain advances as e = L(e_prev, blk).
  always_comb begin
    b_cur = dat_q[blk][col];
    if (col == 4'd0) begin
      e_cur = sq[{leader, 4'h0}];
    end else begin
      e_cur = sq[{e_q, 1'b0, blk}];
    end
  end

  latin_sq_ldiv u_ldiv (
    .sq     (sq),
    .row    (e_cur),
    .target (b_cur),
    .col    (m_cur),
    .found  (found)
  );

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      dat_q     <= '0;
      key_q     <= '0;
      msg_q     <= '0;
      leader    <= '0;
      e_q       <= '0;
      step      <= '0;
      blk       <= '0;
      col       <= '0;
      err_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            dat_q    <= blk_in[511:0];
            key_q    <= k;
            msg_q    <= '0;
            err_q    <= 1'b0;
            // Only bit 0 of k[0] seeds the leader, matching the encoder.
            leader   <= {3'b000, k[0]};
            step     <= 4'd1;
            in_ready <= 1'b0;
            state    <= LEADER;
          end
        end
        LEADER: begin
          leader <= sq[{key_q[step], leader}];
          step   <= step + 4'd1;
          if (step == 4'd15) begin
            blk   <= '0;
            col   <= '0;
            state <= DECODE;
          end
        end
        DECODE: begin
          msg_q[blk][col] <= m_cur;
          err_q           <= err_q | ~found;
          e_q             <= e_cur;
          col             <= col + 4'd1;
          if (col == 4'd15) begin
            blk <= blk + 3'd1;
          end
          if (last_cell) begin
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign msg_out = msg_q;
  assign sq_err  = err_q;

`ifdef AONT_CHECK_EN
  block_t  chk_q;
  block_t  acc;
  nibble_t acc_upd;
  logic    mac_next;
  logic    mac_q;

  // The last accumulator update lands in the same cycle the verdict is
  // registered, so the comparison uses the freshly updated column.
  always_comb begin
    acc_upd  = (blk == 3'd0) ? b_cur : mulmod17_t4(acc[col], b_cur);
    mac_next = 1'b1;
    for (int j = 0; j < LSLEN; j++) begin
      if (mulmod17_t4((4'(j) == col) ? acc_upd : acc[j], key_q[j]) != chk_q[j]) begin
        mac_next = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      chk_q <= '0;
      acc   <= '0;
      mac_q <= 1'b0;
    end else if (accept) begin
      chk_q <= blk_in[575:512];
      acc   <= '0;
      mac_q <= 1'b0;
    end else if (state == DECODE) begin
      acc[col] <= acc_upd;
      if (last_cell) begin
        mac_q <= mac_next;
      end
    end
  end

  assign mac_ok = mac_q;
`else
  logic unused_chk;
  assign unused_chk = ^blk_in[575:512];
  assign mac_ok     = 1'b0;
`endif

endmodule
